// File: rtl/copperv2_bus_pkg.sv
// Copperv2 bus definitions shared by the memory-side blocks.
// Widths, write-response codes and the per-channel state type.
package copperv2_bus_pkg;

    localparam int BUS_DATA_WIDTH = 32;
    localparam int BUS_ADDR_WIDTH = 32;
    localparam int STROBE_WIDTH = BUS_DATA_WIDTH / 8;

    localparam logic RESP_OK = 1'b1;
    localparam logic RESP_RANGE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } chan_state_t;

    // Writes complete in the access cycle, so they jump straight to FULL.
    function automatic chan_state_t chan_next(
        input chan_state_t s,
        input logic accept,
        input logic skip_busy,
        input logic done
    );
        chan_state_t n;
        n = s;
        unique case (s)
            IDLE: begin
                if (accept) begin
                    if (skip_busy) n = FULL;
                    else n = BUSY;
                end
            end
            BUSY: n = FULL;
            FULL: begin
                if (done) n = IDLE;
            end
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/copperv2_resp_slot.sv
// One-entry response register with valid/ready handshake.
// Bits stay put while the consumer stalls.
module copperv2_resp_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bits,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] bits
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            bits <= '0;
        end else if (load) begin
            valid <= 1'b1;
            bits <= load_bits;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/copperv2_mem_ctrl.sv
// Single-port SRAM controller serving the core's ir, dr and dw channels.
// Fixed priority dw > dr > ir, one outstanding request per channel.
module copperv2_mem_ctrl
    import copperv2_bus_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int MEM_WORDS_LOG2 = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic                      bus_ir_addr_ready,
    input  logic                      bus_ir_addr_valid,
    input  logic [ADDR_WIDTH-1:0]     bus_ir_addr_bits,
    input  logic                      bus_ir_data_ready,
    output logic                      bus_ir_data_valid,
    output logic [DATA_WIDTH-1:0]     bus_ir_data_bits,
    output logic                      bus_dr_addr_ready,
    input  logic                      bus_dr_addr_valid,
    input  logic [ADDR_WIDTH-1:0]     bus_dr_addr_bits,
    input  logic                      bus_dr_data_ready,
    output logic                      bus_dr_data_valid,
    output logic [DATA_WIDTH-1:0]     bus_dr_data_bits,
    output logic                      bus_dw_req_ready,
    input  logic                      bus_dw_req_valid,
    input  logic [DATA_WIDTH-1:0]     bus_dw_req_bits_data,
    input  logic [ADDR_WIDTH-1:0]     bus_dw_req_bits_addr,
    input  logic [DATA_WIDTH/8-1:0]   bus_dw_req_bits_strobe,
    input  logic                      bus_dw_resp_ready,
    output logic                      bus_dw_resp_valid,
    output logic                      bus_dw_resp_bits,
    output logic                      mem_en,
    output logic [DATA_WIDTH/8-1:0]   mem_we,
    output logic [MEM_WORDS_LOG2-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int IDX_HI = MEM_WORDS_LOG2 + 1;
    localparam int TAG_LO = MEM_WORDS_LOG2 + 2;

    chan_state_t ir_st;
    chan_state_t dr_st;
    chan_state_t dw_st;

    logic run;
    logic ir_ok_q;
    logic dr_ok_q;

    logic ir_ok;
    logic dr_ok;
    logic dw_ok;
    logic ir_hs;
    logic dr_hs;
    logic dw_hs;
    logic dr_req;
    logic dw_req;
    logic ir_done;
    logic dr_done;
    logic dw_done;
    logic ir_load;
    logic dr_load;
    logic [DATA_WIDTH-1:0] ir_rd;
    logic [DATA_WIDTH-1:0] dr_rd;
    logic dw_code;
    logic unused_lsbs;

    assign unused_lsbs = ^{bus_ir_addr_bits[1:0],
                           bus_dr_addr_bits[1:0],
                           bus_dw_req_bits_addr[1:0]};

    assign ir_ok = ~|bus_ir_addr_bits[ADDR_WIDTH-1:TAG_LO];
    assign dr_ok = ~|bus_dr_addr_bits[ADDR_WIDTH-1:TAG_LO];
    assign dw_ok = ~|bus_dw_req_bits_addr[ADDR_WIDTH-1:TAG_LO];

    // A higher-priority channel only blocks when it can actually be taken.
    assign dw_req = bus_dw_req_valid & (dw_st == IDLE);
    assign dr_req = bus_dr_addr_valid & (dr_st == IDLE);

    assign bus_dw_req_ready = run & (dw_st == IDLE);
    assign bus_dr_addr_ready = run & (dr_st == IDLE) & ~dw_req;
    assign bus_ir_addr_ready = run & (ir_st == IDLE) & ~dw_req & ~dr_req;

    assign dw_hs = bus_dw_req_valid & bus_dw_req_ready;
    assign dr_hs = bus_dr_addr_valid & bus_dr_addr_ready;
    assign ir_hs = bus_ir_addr_valid & bus_ir_addr_ready;

    assign ir_done = bus_ir_data_valid & bus_ir_data_ready;
    assign dr_done = bus_dr_data_valid & bus_dr_data_ready;
    assign dw_done = bus_dw_resp_valid & bus_dw_resp_ready;

    always_comb begin
        mem_en = 1'b0;
        mem_we = '0;
        mem_addr = '0;
        mem_wdata = '0;
        unique case (1'b1)
            dw_hs && dw_ok: begin
                mem_en = 1'b1;
                mem_we = bus_dw_req_bits_strobe;
                mem_addr = bus_dw_req_bits_addr[IDX_HI:2];
                mem_wdata = bus_dw_req_bits_data;
            end
            dr_hs && dr_ok: begin
                mem_en = 1'b1;
                mem_addr = bus_dr_addr_bits[IDX_HI:2];
            end
            ir_hs && ir_ok: begin
                mem_en = 1'b1;
                mem_addr = bus_ir_addr_bits[IDX_HI:2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
            ir_st <= IDLE;
            dr_st <= IDLE;
            dw_st <= IDLE;
            ir_ok_q <= 1'b0;
            dr_ok_q <= 1'b0;
        end else begin
            run <= 1'b1;
            ir_st <= chan_next(ir_st, ir_hs, 1'b0, ir_done);
            dr_st <= chan_next(dr_st, dr_hs, 1'b0, dr_done);
            dw_st <= chan_next(dw_st, dw_hs, 1'b1, dw_done);
            if (ir_hs) ir_ok_q <= ir_ok;
            if (dr_hs) dr_ok_q <= dr_ok;
        end
    end

    // SRAM data is valid in the BUSY cycle; out-of-range reads return 0.
    assign ir_load = (ir_st == BUSY);
    assign dr_load = (dr_st == BUSY);
    assign ir_rd = ir_ok_q ? mem_rdata : '0;
    assign dr_rd = dr_ok_q ? mem_rdata : '0;
    assign dw_code = dw_ok ? RESP_OK : RESP_RANGE;

    copperv2_resp_slot #(
        .WIDTH(DATA_WIDTH)
    ) u_ir_slot (
        .clock(clock),
        .reset(reset),
        .load(ir_load),
        .load_bits(ir_rd),
        .ready(bus_ir_data_ready),
        .valid(bus_ir_data_valid),
        .bits(bus_ir_data_bits)
    );

    copperv2_resp_slot #(
        .WIDTH(DATA_WIDTH)
    ) u_dr_slot (
        .clock(clock),
        .reset(reset),
        .load(dr_load),
        .load_bits(dr_rd),
        .ready(bus_dr_data_ready),
        .valid(bus_dr_data_valid),
        .bits(bus_dr_data_bits)
    );

    copperv2_resp_slot #(
        .WIDTH(1)
    ) u_dw_slot (
        .clock(clock),
        .reset(reset),
        .load(dw_hs),
        .load_bits(dw_code),
        .ready(bus_dw_resp_ready),
        .valid(bus_dw_resp_valid),
        .bits(bus_dw_resp_bits)
    );

endmodule

// File: tb/tb_copperv2_mem_ctrl.sv
// Bench for copperv2_mem_ctrl with an SRAM model and per-channel scoreboards.
// Channel index: 0 = ir, 1 = dr, 2 = dw.
module tb_copperv2_mem_ctrl;

    logic clock = 1'b0;
    logic reset;
    logic bus_ir_addr_ready;
    logic bus_ir_addr_valid;
    logic [31:0] bus_ir_addr_bits;
    logic bus_ir_data_ready;
    logic bus_ir_data_valid;
    logic [31:0] bus_ir_data_bits;
    logic bus_dr_addr_ready;
    logic bus_dr_addr_valid;
    logic [31:0] bus_dr_addr_bits;
    logic bus_dr_data_ready;
    logic bus_dr_data_valid;
    logic [31:0] bus_dr_data_bits;
    logic bus_dw_req_ready;
    logic bus_dw_req_valid;
    logic [31:0] bus_dw_req_bits_data;
    logic [31:0] bus_dw_req_bits_addr;
    logic [3:0] bus_dw_req_bits_strobe;
    logic bus_dw_resp_ready;
    logic bus_dw_resp_valid;
    logic bus_dw_resp_bits;
    logic mem_en;
    logic [3:0] mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] sram [0:4095];
    logic [31:0] ref_mem [int];
    logic [31:0] ir_q [$];
    logic [31:0] dr_q [$];
    logic dw_q [$];

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc [3];
    int rsp_cyc [3];
    logic [31:0] last_data [3];
    logic hs_mem_en;
    logic [3:0] hs_mem_we;
    logic [11:0] hs_mem_addr;
    logic [31:0] hs_mem_wdata;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_en) begin
            mem_rdata <= sram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    copperv2_mem_ctrl dut (
        .clock(clock),
        .reset(reset),
        .bus_ir_addr_ready(bus_ir_addr_ready),
        .bus_ir_addr_valid(bus_ir_addr_valid),
        .bus_ir_addr_bits(bus_ir_addr_bits),
        .bus_ir_data_ready(bus_ir_data_ready),
        .bus_ir_data_valid(bus_ir_data_valid),
        .bus_ir_data_bits(bus_ir_data_bits),
        .bus_dr_addr_ready(bus_dr_addr_ready),
        .bus_dr_addr_valid(bus_dr_addr_valid),
        .bus_dr_addr_bits(bus_dr_addr_bits),
        .bus_dr_data_ready(bus_dr_data_ready),
        .bus_dr_data_valid(bus_dr_data_valid),
        .bus_dr_data_bits(bus_dr_data_bits),
        .bus_dw_req_ready(bus_dw_req_ready),
        .bus_dw_req_valid(bus_dw_req_valid),
        .bus_dw_req_bits_data(bus_dw_req_bits_data),
        .bus_dw_req_bits_addr(bus_dw_req_bits_addr),
        .bus_dw_req_bits_strobe(bus_dw_req_bits_strobe),
        .bus_dw_resp_ready(bus_dw_resp_ready),
        .bus_dw_resp_valid(bus_dw_resp_valid),
        .bus_dw_resp_bits(bus_dw_resp_bits),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int idx;
        idx = int'(a[13:2]);
        if (a[31:14] != 18'd0) return 32'h0;
        if (!ref_mem.exists(idx)) return 32'h0;
        return ref_mem[idx];
    endfunction

    // One clock: record handshakes, push expectations, pop and compare responses.
    task automatic step();
        int idx;
        logic [31:0] w;
        @(negedge clock);
        cyc++;
        if (bus_dw_req_valid && bus_dw_req_ready) begin
            hs_cyc[2] = cyc;
            hs_mem_en = mem_en;
            hs_mem_we = mem_we;
            hs_mem_addr = mem_addr;
            hs_mem_wdata = mem_wdata;
            if (bus_dw_req_bits_addr[31:14] == 18'd0) begin
                idx = int'(bus_dw_req_bits_addr[13:2]);
                w = ref_read(bus_dw_req_bits_addr);
                for (int b = 0; b < 4; b++)
                    if (bus_dw_req_bits_strobe[b])
                        w[b*8 +: 8] = bus_dw_req_bits_data[b*8 +: 8];
                ref_mem[idx] = w;
                dw_q.push_back(1'b1);
            end else begin
                dw_q.push_back(1'b0);
            end
        end
        if (bus_dr_addr_valid && bus_dr_addr_ready) begin
            hs_cyc[1] = cyc;
            hs_mem_en = mem_en;
            hs_mem_addr = mem_addr;
            dr_q.push_back(ref_read(bus_dr_addr_bits));
        end
        if (bus_ir_addr_valid && bus_ir_addr_ready) begin
            hs_cyc[0] = cyc;
            hs_mem_en = mem_en;
            hs_mem_addr = mem_addr;
            ir_q.push_back(ref_read(bus_ir_addr_bits));
        end
        if (bus_dw_resp_valid && bus_dw_resp_ready) begin
            rsp_cyc[2] = cyc;
            last_data[2] = {31'd0, bus_dw_resp_bits};
            vectors++;
            if (dw_q.size() == 0) begin
                errors++;
                $display("FAIL dw_resp unexpected: got %0d", bus_dw_resp_bits);
            end else if (bus_dw_resp_bits !== dw_q[0]) begin
                errors++;
                $display("FAIL dw_resp: got %0d want %0d", bus_dw_resp_bits, dw_q[0]);
            end
            if (dw_q.size() != 0) void'(dw_q.pop_front());
        end
        if (bus_dr_data_valid && bus_dr_data_ready) begin
            rsp_cyc[1] = cyc;
            last_data[1] = bus_dr_data_bits;
            vectors++;
            if (dr_q.size() == 0) begin
                errors++;
                $display("FAIL dr_data unexpected: got %h", bus_dr_data_bits);
            end else if (bus_dr_data_bits !== dr_q[0]) begin
                errors++;
                $display("FAIL dr_data: got %h want %h", bus_dr_data_bits, dr_q[0]);
            end
            if (dr_q.size() != 0) void'(dr_q.pop_front());
        end
        if (bus_ir_data_valid && bus_ir_data_ready) begin
            rsp_cyc[0] = cyc;
            last_data[0] = bus_ir_data_bits;
            vectors++;
            if (ir_q.size() == 0) begin
                errors++;
                $display("FAIL ir_data unexpected: got %h", bus_ir_data_bits);
            end else if (bus_ir_data_bits !== ir_q[0]) begin
                errors++;
                $display("FAIL ir_data: got %h want %h", bus_ir_data_bits, ir_q[0]);
            end
            if (ir_q.size() != 0) void'(ir_q.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_until(input int ch, input int bound);
        int start;
        start = cyc;
        forever begin
            step();
            if (hs_cyc[ch] == cyc) break;
            if (cyc - start >= bound) begin
                vectors++;
                errors++;
                $display("FAIL handshake_timeout ch%0d: got none want within %0d", ch, bound);
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int ch, input int after, input int bound);
        int start;
        start = cyc;
        while (rsp_cyc[ch] <= after) begin
            if (cyc - start >= bound) begin
                vectors++;
                errors++;
                $display("FAIL response_timeout ch%0d: got none want within %0d", ch, bound);
                break;
            end
            step();
        end
    endtask

    task automatic drive_dw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus_dw_req_bits_addr = a;
        bus_dw_req_bits_data = d;
        bus_dw_req_bits_strobe = s;
        bus_dw_req_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_ir_addr_valid = 1'b1;
        bus_dr_addr_valid = 1'b1;
        bus_dw_req_valid = 1'b1;
        bus_ir_addr_bits = 32'h0;
        bus_dr_addr_bits = 32'h0;
        bus_dw_req_bits_addr = 32'h0;
        bus_dw_req_bits_data = 32'hFFFF_FFFF;
        bus_dw_req_bits_strobe = 4'hF;
        bus_ir_data_ready = 1'b1;
        bus_dr_data_ready = 1'b1;
        bus_dw_resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        vectors++;
        if ({bus_ir_addr_ready, bus_dr_addr_ready, bus_dw_req_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 000",
                     {bus_ir_addr_ready, bus_dr_addr_ready, bus_dw_req_ready});
        end
        vectors++;
        if ({bus_ir_data_valid, bus_dr_data_valid, bus_dw_resp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_valid: got %b want 000",
                     {bus_ir_data_valid, bus_dr_data_valid, bus_dw_resp_valid});
        end
        vectors++;
        if ({bus_ir_data_bits, bus_dr_data_bits, bus_dw_resp_bits} !== 65'd0) begin
            errors++;
            $display("FAIL reset_bits: got %h %h %b want 0",
                     bus_ir_data_bits, bus_dr_data_bits, bus_dw_resp_bits);
        end
        vectors++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== 49'd0) begin
            errors++;
            $display("FAIL reset_mem: got en=%b we=%h addr=%h wdata=%h want 0",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        bus_ir_addr_valid = 1'b0;
        bus_dr_addr_valid = 1'b0;
        bus_dw_req_valid = 1'b0;
        reset = 1'b1;
        step();
        vectors++;
        if ({bus_ir_addr_ready, bus_dr_addr_ready, bus_dw_req_ready} !== 3'b111) begin
            errors++;
            $display("FAIL idle_ready: got %b want 111",
                     {bus_ir_addr_ready, bus_dr_addr_ready, bus_dw_req_ready});
        end
    endtask

    task automatic test_write_read();
        drive_dw(32'h10, 32'hDEAD_BEEF, 4'hF);
        run_until(2, 10);
        bus_dw_req_valid = 1'b0;
        vectors++;
        if ({hs_mem_en, hs_mem_we, hs_mem_addr, hs_mem_wdata} !== {1'b1, 4'hF, 12'h004, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL write_mem: got en=%b we=%h addr=%h wdata=%h want 1 f 004 deadbeef",
                     hs_mem_en, hs_mem_we, hs_mem_addr, hs_mem_wdata);
        end
        wait_rsp(2, hs_cyc[2], 5);
        vectors++;
        if (rsp_cyc[2] != hs_cyc[2] + 1) begin
            errors++;
            $display("FAIL write_latency: got %0d want 1", rsp_cyc[2] - hs_cyc[2]);
        end
        bus_dr_addr_bits = 32'h10;
        bus_dr_addr_valid = 1'b1;
        run_until(1, 10);
        bus_dr_addr_valid = 1'b0;
        wait_rsp(1, hs_cyc[1], 6);
        vectors++;
        if (rsp_cyc[1] != hs_cyc[1] + 2) begin
            errors++;
            $display("FAIL read_latency: got %0d want 2", rsp_cyc[1] - hs_cyc[1]);
        end
        vectors++;
        if (last_data[1] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_deadbeef: got %h want deadbeef", last_data[1]);
        end
    endtask

    task automatic test_strobe();
        drive_dw(32'h10, 32'h0000_00AA, 4'h1);
        run_until(2, 10);
        bus_dw_req_valid = 1'b0;
        vectors++;
        if (hs_mem_we !== 4'h1) begin
            errors++;
            $display("FAIL strobe_we: got %h want 1", hs_mem_we);
        end
        wait_rsp(2, hs_cyc[2], 5);
        bus_dr_addr_bits = 32'h13;
        bus_dr_addr_valid = 1'b1;
        run_until(1, 10);
        bus_dr_addr_valid = 1'b0;
        wait_rsp(1, hs_cyc[1], 6);
        vectors++;
        if (last_data[1] !== 32'hDEAD_BEAA) begin
            errors++;
            $display("FAIL strobe_merge: got %h want deadbeaa", last_data[1]);
        end
    endtask

    task automatic test_priority();
        int start;
        start = cyc;
        drive_dw(32'h20, 32'h1234_5678, 4'hF);
        bus_dr_addr_bits = 32'h10;
        bus_dr_addr_valid = 1'b1;
        bus_ir_addr_bits = 32'h20;
        bus_ir_addr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (hs_cyc[2] == cyc) bus_dw_req_valid = 1'b0;
            if (hs_cyc[1] == cyc) bus_dr_addr_valid = 1'b0;
            if (hs_cyc[0] == cyc) bus_ir_addr_valid = 1'b0;
            if (!bus_dw_req_valid && !bus_dr_addr_valid && !bus_ir_addr_valid) break;
        end
        vectors++;
        if (hs_cyc[2] <= start || hs_cyc[1] != hs_cyc[2] + 1 || hs_cyc[0] != hs_cyc[2] + 2) begin
            errors++;
            $display("FAIL priority_order: got dw=%0d dr=%0d ir=%0d want N,N+1,N+2",
                     hs_cyc[2], hs_cyc[1], hs_cyc[0]);
        end
        bus_ir_addr_valid = 1'b0;
        bus_dr_addr_valid = 1'b0;
        bus_dw_req_valid = 1'b0;
        wait_rsp(0, hs_cyc[0], 6);
        vectors++;
        if (last_data[0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL priority_raw: got %h want 12345678", last_data[0]);
        end
        vectors++;
        if (ir_q.size() + dr_q.size() + dw_q.size() != 0) begin
            errors++;
            $display("FAIL priority_drain: got %0d pending want 0",
                     ir_q.size() + dr_q.size() + dw_q.size());
        end
    endtask

    task automatic test_hold();
        bus_dr_data_ready = 1'b0;
        bus_dr_addr_bits = 32'h10;
        bus_dr_addr_valid = 1'b1;
        run_until(1, 10);
        bus_dr_addr_valid = 1'b0;
        step();
        bus_ir_addr_bits = 32'h20;
        bus_ir_addr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus_dr_data_valid !== 1'b1 || bus_dr_data_bits !== 32'hDEAD_BEAA) begin
                errors++;
                $display("FAIL hold_stable: got valid=%b bits=%h want 1 deadbeaa",
                         bus_dr_data_valid, bus_dr_data_bits);
            end
            vectors++;
            if (bus_dr_addr_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_addr_ready: got %b want 0", bus_dr_addr_ready);
            end
            step();
            if (hs_cyc[0] == cyc) bus_ir_addr_valid = 1'b0;
        end
        bus_ir_addr_valid = 1'b0;
        vectors++;
        if (rsp_cyc[0] != hs_cyc[0] + 2) begin
            errors++;
            $display("FAIL hold_ir_fetch: got %0d want 2", rsp_cyc[0] - hs_cyc[0]);
        end
        bus_dr_data_ready = 1'b1;
        wait_rsp(1, hs_cyc[1], 4);
    endtask

    task automatic test_out_of_range();
        drive_dw(32'h0001_0000, 32'h0000_0055, 4'hF);
        run_until(2, 10);
        bus_dw_req_valid = 1'b0;
        vectors++;
        if (hs_mem_en !== 1'b0) begin
            errors++;
            $display("FAIL oor_write_en: got %b want 0", hs_mem_en);
        end
        wait_rsp(2, hs_cyc[2], 5);
        vectors++;
        if (last_data[2] !== 32'd0) begin
            errors++;
            $display("FAIL oor_write_resp: got %0d want 0", last_data[2]);
        end
        bus_dr_addr_bits = 32'h0001_0000;
        bus_dr_addr_valid = 1'b1;
        run_until(1, 10);
        bus_dr_addr_valid = 1'b0;
        vectors++;
        if (hs_mem_en !== 1'b0) begin
            errors++;
            $display("FAIL oor_read_en: got %b want 0", hs_mem_en);
        end
        wait_rsp(1, hs_cyc[1], 6);
        vectors++;
        if (last_data[1] !== 32'd0) begin
            errors++;
            $display("FAIL oor_read_data: got %h want 0", last_data[1]);
        end
    endtask

    task automatic test_reset_mid();
        drive_dw(32'h0, 32'h0BAD_F00D, 4'hF);
        run_until(2, 10);
        bus_dw_req_valid = 1'b0;
        wait_rsp(2, hs_cyc[2], 5);
        bus_dr_addr_bits = 32'h10;
        bus_dr_addr_valid = 1'b1;
        run_until(1, 10);
        bus_dr_addr_valid = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus_ir_addr_ready, bus_dr_addr_ready, bus_dw_req_ready,
             bus_ir_data_valid, bus_dr_data_valid, bus_dw_resp_valid, mem_en} !== 7'd0) begin
            errors++;
            $display("FAIL midreset_clear: got %b want 0000000",
                     {bus_ir_addr_ready, bus_dr_addr_ready, bus_dw_req_ready,
                      bus_ir_data_valid, bus_dr_data_valid, bus_dw_resp_valid, mem_en});
        end
        dr_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({bus_ir_data_valid, bus_dr_data_valid, bus_dw_resp_valid} !== 3'b000) begin
                errors++;
                $display("FAIL midreset_stale: got %b want 000",
                         {bus_ir_data_valid, bus_dr_data_valid, bus_dw_resp_valid});
            end
        end
        bus_ir_addr_bits = 32'h0;
        bus_ir_addr_valid = 1'b1;
        run_until(0, 10);
        bus_ir_addr_valid = 1'b0;
        wait_rsp(0, hs_cyc[0], 6);
        vectors++;
        if (last_data[0] !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL midreset_fetch: got %h want 0badf00d", last_data[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            hs_cyc[i] = -1;
            rsp_cyc[i] = -1;
            last_data[i] = 32'h0;
        end
        hs_mem_en = 1'b0;
        hs_mem_we = 4'h0;
        hs_mem_addr = 12'h0;
        hs_mem_wdata = 32'h0;
        test_reset();
        test_write_read();
        test_strobe();
        test_priority();
        test_hold();
        test_out_of_range();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/copperv2_mem_ctrl.md
# copperv2_mem_ctrl

- Single-port memory controller on the memory side of the Copperv2 core.
- Consumes the core's three bus channels: instruction read (ir), data read (dr) and data write (dw).
- Services them against one synchronous single-port SRAM with byte write enables, and returns read data and write responses on the matching response channels.
- Sits directly downstream of the core; in simulation it replaces the behavioural bus model, and on FPGA it fronts block RAM.

## Interface
Parameters:
- DATA_WIDTH, 32, bus and SRAM word width
- ADDR_WIDTH, 32, byte address width on the bus
- MEM_WORDS_LOG2, 12, log2 of SRAM depth in words (default 16 KiB)

Ports:
- clock  in  1  single clock domain for the whole block
- reset  in  1  asynchronous, active-low (0 = reset); all state clears immediately on assertion
- bus_ir_addr_ready  out  1  instruction fetch address accepted
- bus_ir_addr_valid  in  1  fetch request present
- bus_ir_addr_bits  in  ADDR_WIDTH  fetch byte address
- bus_ir_data_ready  in  1  core accepts fetched word
- bus_ir_data_valid  out  1  fetched word present
- bus_ir_data_bits  out  DATA_WIDTH  fetched word
- bus_dr_addr_ready/valid/bits: same definition as the ir address channel, for data reads
- bus_dr_data_ready/valid/bits: same definition as the ir data channel, for data reads
- bus_dw_req_ready  out  1  write accepted
- bus_dw_req_valid  in  1  write present
- bus_dw_req_bits_data  in  DATA_WIDTH  write data
- bus_dw_req_bits_addr  in  ADDR_WIDTH  write byte address
- bus_dw_req_bits_strobe  in  DATA_WIDTH/8  byte enables
- bus_dw_resp_ready  in  1  core accepts write response
- bus_dw_resp_valid  out  1  write response present
- bus_dw_resp_bits  out  1  1 = write performed, 0 = address out of range (dropped)
- mem_en  out  1  SRAM access this cycle
- mem_we  out  DATA_WIDTH/8  SRAM byte write enables
- mem_addr  out  MEM_WORDS_LOG2  SRAM word address
- mem_wdata  out  DATA_WIDTH  SRAM write data
- mem_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access

## Operation
- Word index = addr[MEM_WORDS_LOG2+1:2]. addr[1:0] is ignored; all accesses are word-aligned, and byte lanes are selected only by strobe.
- Range check: an address is in range iff addr[ADDR_WIDTH-1:MEM_WORDS_LOG2+2] == 0.
  - Out-of-range read: no SRAM access; returns 0.
  - Out-of-range write: no SRAM access; response bit 0.
- Fixed-priority grant among requests with valid high: dw > dr > ir. Exactly one SRAM access per cycle at most.
- Each channel allows one outstanding request. Per-channel state is a 2-bit FSM:
  - IDLE -> BUSY on address/request handshake.
  - BUSY -> FULL when the response is registered.
  - FULL -> IDLE on response handshake.
  - Write channel: the IDLE -> FULL step takes one cycle (BUSY is skipped).
- x_ready = granted(x) AND channel x IDLE. Ready may depend combinationally on the valid of higher-priority channels; it never depends on x_valid itself.
- Response registers hold bits stable while valid is high and ready is low.
- Strobe 0 on an in-range write: SRAM access with mem_we = 0; response bit 1.

## Timing
- Reset values: all *_ready = 0, all *_valid = 0, all *_bits = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. All channel FSMs go to IDLE; in-flight reads are discarded.
- Read: handshake in cycle N drives mem_en=1, mem_addr combinationally in N. mem_rdata is sampled at the end of N+1. data_valid rises in N+2. Latency 2; maximum throughput 1 per 3 cycles per channel when ready is held high.
- Write: handshake in N drives mem_en=1, mem_we=strobe in N. resp_valid rises in N+1. Latency 1.
- Read-after-write: a read of the same word accepted in N+1 or later returns the new data.
- Simultaneous dw and dr valid: dw accepted in N, dr in N+1. ir accepted only in a cycle where neither dw nor dr is granted.
- Response held (consumer ready low): the channel remains FULL and its address ready stays 0. Other channels are unaffected.
- Reset asserted mid-access: outputs clear asynchronously, no response is ever produced for the aborted access, and the SRAM content is not restored.

## Structure
- Shared package copperv2_bus_pkg holds:
  - DATA_WIDTH/ADDR_WIDTH defaults and STROBE_WIDTH
  - write-response codes RESP_OK=1, RESP_RANGE=0
  - the channel-state enum {IDLE, BUSY, FULL}
- One sub-module, copperv2_resp_slot: a one-entry response register with valid/ready and an enable-load input. It is instantiated three times (ir data, dr data, dw resp); the arbiter and range check stay in the top.

## Test plan
- Write 0xDEADBEEF to 0x10 (strobe 0xF), then read dr 0x10:
  - write: resp_bits=1 one cycle after the handshake
  - read: data 0xDEADBEEF two cycles after the handshake
- Write 0x000000AA to 0x10 with strobe 0x1 over the previous value, then read -> 0xDEADBEAA.
- dw, dr and ir valid in the same cycle -> accepted in cycles N, N+1, N+2 respectively; all three responses are correct.
- dr read with bus_dr_data_ready held 0 for 5 cycles:
  - data_valid and bits remain stable
  - bus_dr_addr_ready stays 0
  - ir fetches still complete
- Write to 0x00010000 (out of range) -> mem_en stays 0, resp_bits=0. Read of the same address returns 0.
- Assert reset during a read's BUSY cycle, then release it:
  - all valid and ready outputs are 0 immediately
  - no stale data_valid appears after release
  - a new fetch of 0x0 completes normally
